// File: rtl/tpu_pkg.sv
// Shared constants and helpers for the TPU array and its processing elements.
package tpu_pkg;

    // Default operand and accumulator widths shared with the array top
    localparam int BITS_AB_DEF = 8;
    localparam int BITS_C_DEF  = 16;

    // Largest positive value of a signed number of the given width
    function automatic longint sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    // Most negative value of a signed number of the given width
    function automatic longint sat_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/tpumac_pipe_if.sv
// Bus between the array controller / neighbours and one MAC processing element.
interface tpumac_pipe_if
    import tpu_pkg::*;
#(
    parameter int BITS_AB = BITS_AB_DEF,
    parameter int BITS_C  = BITS_C_DEF
) ();

    logic                      en;
    logic                      WrEn;
    logic                      clr;
    logic signed [BITS_AB-1:0] Ain;
    logic signed [BITS_AB-1:0] Bin;
    logic signed [BITS_C-1:0]  Cin;
    logic signed [BITS_AB-1:0] Aout;
    logic signed [BITS_AB-1:0] Bout;
    logic signed [BITS_C-1:0]  Cout;
    logic                      ovf;

    modport master (
        output en, WrEn, clr, Ain, Bin, Cin,
        input  Aout, Bout, Cout, ovf
    );

    modport slave (
        input  en, WrEn, clr, Ain, Bin, Cin,
        output Aout, Bout, Cout, ovf
    );

endinterface

// File: rtl/tpu_sat_add.sv
// Combinational accumulator adder with optional clamping and an overflow bit.
// The addend is one bit wider than the accumulator so any product fits.
module tpu_sat_add
    import tpu_pkg::*;
#(
    parameter int W        = BITS_C_DEF,
    parameter bit SATURATE = 1'b1
) (
    input  logic signed [W-1:0] acc,
    input  logic signed [W:0]   addend,
    output logic signed [W-1:0] sum,
    output logic                ovf
);

    localparam logic signed [W-1:0] MAX_V = W'(sat_max(W));
    localparam logic signed [W-1:0] MIN_V = W'(sat_min(W));

    logic signed [W:0] full;

    // Widen, add, then clamp or wrap when the result leaves the W-bit range
    always_comb begin
        full = $signed({acc[W-1], acc}) + addend;
        ovf  = full[W] ^ full[W-1];
        sum  = full[W-1:0];
        if (ovf && SATURATE) begin
            sum = full[W] ? MIN_V : MAX_V;
        end
    end

endmodule

// File: rtl/tpumac_pipe.sv
// Systolic MAC processing element: forwards A/B, accumulates signed A*B
// with an optional multiplier register stage and saturating/wrapping sum.
module tpumac_pipe
    import tpu_pkg::*;
#(
    parameter int BITS_AB  = BITS_AB_DEF,
    parameter int BITS_C   = BITS_C_DEF,
    parameter int MUL_PIPE = 1,
    parameter bit SATURATE = 1'b1
) (
    input logic          clk,
    input logic          rst,
    tpumac_pipe_if.slave bus
);

    if (BITS_C < 2 * BITS_AB) begin : g_bad_width
        $error("tpumac_pipe: BITS_C must be at least 2*BITS_AB");
    end

    logic signed [2*BITS_AB-1:0] prod_now;
    logic signed [BITS_C:0]      prod_ext;
    logic signed [BITS_C:0]      addend;
    logic                        add_en;
    logic signed [BITS_C-1:0]    sum;
    logic                        sum_ovf;
    logic signed [BITS_C-1:0]    acc_q;
    logic                        ovf_q;
    logic signed [BITS_AB-1:0]   a_q;
    logic signed [BITS_AB-1:0]   b_q;

    assign prod_now = bus.Ain * bus.Bin;
    assign prod_ext = (BITS_C + 1)'(prod_now);

    if (MUL_PIPE != 0) begin : g_pipe
        logic signed [BITS_C:0] prod_q;
        logic                   p_v;

        // Product register; clr kills the in-flight product so it never lands
        always_ff @(posedge clk) begin
            if (rst) begin
                prod_q <= '0;
                p_v    <= 1'b0;
            end else begin
                prod_q <= prod_ext;
                p_v    <= bus.en && !bus.clr;
            end
        end

        assign add_en = p_v;
        assign addend = prod_q;
    end else begin : g_direct
        assign add_en = bus.en;
        assign addend = prod_ext;
    end

    tpu_sat_add #(
        .W        (BITS_C),
        .SATURATE (SATURATE)
    ) u_add (
        .acc    (acc_q),
        .addend (addend),
        .sum    (sum),
        .ovf    (sum_ovf)
    );

    // Systolic forwarding of the operands to the neighbouring cells
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else if (bus.en) begin
            a_q <= bus.Ain;
            b_q <= bus.Bin;
        end
    end

    // Accumulator and sticky overflow; clr beats preload beats accumulate
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (bus.clr) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (bus.WrEn) begin
            acc_q <= bus.Cin;
        end else if (add_en) begin
            acc_q <= sum;
            if (sum_ovf) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.Aout = a_q;
    assign bus.Bout = b_q;
    assign bus.Cout = acc_q;
    assign bus.ovf  = ovf_q;

endmodule
